// File: rtl/sht40_meas_ctrl.sv
// SHT40 measurement sequencer: issues the measure command, waits out the conversion,
// reads six bytes through a byte-level I2C master, verifies both CRC-8s and publishes raw words.
module sht40_meas_ctrl #(
    parameter logic [6:0]  SHT_ADDR    = 7'h44,
    parameter logic [7:0]  MEAS_CMD    = 8'hFD,
    parameter int unsigned WAIT_CYCLES = 900000,
    parameter int unsigned MAX_RETRIES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        txn_valid,
    input  logic        txn_ready,
    output logic        txn_rw,
    output logic [6:0]  txn_addr,
    output logic [2:0]  txn_len,
    output logic [7:0]  txn_wdata,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        txn_done,
    input  logic        txn_nack,
    output logic        busy,
    output logic        data_valid,
    output logic [15:0] temperature,
    output logic [15:0] humidity,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [2:0]  dbg_state
);

    // Handshake: a request transfers on a cycle where txn_valid & txn_ready are both high;
    // txn_valid, txn_rw and txn_len hold steady from the first request cycle until that transfer.

    localparam int unsigned CNT_W       = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [2:0] RETRY_LIMIT  = 3'(MAX_RETRIES);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_WAIT = 3'd2,
        DELAY   = 3'd3,
        RD_REQ  = 3'd4,
        RD_WAIT = 3'd5,
        CHECK   = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       retries_q, retries_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       crc_q, crc_d;
    logic             mism_q, mism_d;
    logic [1:0]       fail_q, fail_d;
    logic [15:0]      t_stage_q, t_stage_d;
    logic [15:0]      h_stage_q, h_stage_d;
    logic [15:0]      temperature_q, temperature_d;
    logic [15:0]      humidity_q, humidity_d;

    // Folds one byte into the CRC-8 (poly 0x31, MSB first) in a single cycle.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h31) : (c << 1);
        end
        return c;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            retries_q     <= '0;
            idx_q         <= '0;
            crc_q         <= 8'hFF;
            mism_q        <= 1'b0;
            fail_q        <= 2'd0;
            t_stage_q     <= '0;
            h_stage_q     <= '0;
            temperature_q <= '0;
            humidity_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            retries_q     <= retries_d;
            idx_q         <= idx_d;
            crc_q         <= crc_d;
            mism_q        <= mism_d;
            fail_q        <= fail_d;
            t_stage_q     <= t_stage_d;
            h_stage_q     <= h_stage_d;
            temperature_q <= temperature_d;
            humidity_q    <= humidity_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        retries_d     = retries_q;
        idx_d         = idx_q;
        crc_d         = crc_q;
        mism_d        = mism_q;
        fail_d        = fail_q;
        t_stage_d     = t_stage_q;
        h_stage_d     = h_stage_q;
        temperature_d = temperature_q;
        humidity_d    = humidity_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = WR_REQ;
                    retries_d = '0;
                    fail_d    = 2'd0;
                end
            end
            WR_REQ: begin
                if (txn_ready) state_d = WR_WAIT;
            end
            WR_WAIT: begin
                if (txn_done) begin
                    if (txn_nack) begin
                        fail_d  = 2'd1;
                        state_d = CHECK;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = DELAY;
                    end
                end
            end
            DELAY: begin
                if (cnt_q == '0) state_d = RD_REQ;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            RD_REQ: begin
                if (txn_ready) begin
                    state_d = RD_WAIT;
                    idx_d   = '0;
                    crc_d   = 8'hFF;
                    mism_d  = 1'b0;
                end
            end
            RD_WAIT: begin
                // The byte is absorbed first so a byte coinciding with txn_done still counts.
                if (rx_valid && (idx_q < 3'd6)) begin
                    idx_d = idx_q + 3'd1;
                    case (idx_q)
                        3'd0: begin t_stage_d[15:8] = rx_data; crc_d = crc8_step(crc_q, rx_data); end
                        3'd1: begin t_stage_d[7:0]  = rx_data; crc_d = crc8_step(crc_q, rx_data); end
                        3'd3: begin h_stage_d[15:8] = rx_data; crc_d = crc8_step(crc_q, rx_data); end
                        3'd4: begin h_stage_d[7:0]  = rx_data; crc_d = crc8_step(crc_q, rx_data); end
                        default: begin
                            if (rx_data != crc_q) mism_d = 1'b1;
                            crc_d = 8'hFF;
                        end
                    endcase
                end
                if (txn_done) begin
                    if (txn_nack || (idx_d != 3'd6)) begin
                        if (retries_q < RETRY_LIMIT) begin
                            retries_d = retries_q + 3'd1;
                            cnt_d     = CNT_LOAD;
                            state_d   = DELAY;
                        end else begin
                            fail_d  = 2'd2;
                            state_d = CHECK;
                        end
                    end else if (mism_d) begin
                        fail_d  = 2'd3;
                        state_d = CHECK;
                    end else begin
                        fail_d        = 2'd0;
                        temperature_d = t_stage_d;
                        humidity_d    = h_stage_d;
                        state_d       = CHECK;
                    end
                end
            end
            CHECK: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Every termination passes through CHECK, so result pulses land one cycle after the final done.
    assign txn_valid   = (state_q == WR_REQ) || (state_q == RD_REQ);
    assign txn_rw      = (state_q == RD_REQ);
    assign txn_len     = (state_q == RD_REQ) ? 3'd6 : ((state_q == WR_REQ) ? 3'd1 : 3'd0);
    assign txn_addr    = SHT_ADDR;
    assign txn_wdata   = MEAS_CMD;
    assign busy        = (state_q != IDLE);
    assign data_valid  = (state_q == CHECK) && (fail_q == 2'd0);
    assign err         = (state_q == CHECK) && (fail_q != 2'd0);
    assign err_code    = err ? fail_q : 2'd0;
    assign temperature = temperature_q;
    assign humidity    = humidity_q;
    assign dbg_state   = state_q;

endmodule

// File: doc/sht40_meas_ctrl.md
# sht40_meas_ctrl

Measurement sequencer for the SHT40 temperature/humidity sensor. It sits between a measurement trigger and the byte-level I2C master. On a trigger it issues the measure command, waits out the conversion time, reads the six result bytes, checks both CRC-8 checksums and publishes raw 16-bit temperature and humidity words. Conversion to physical units is done downstream.

## Interface
- SHT_ADDR, 7'h44, sensor 7-bit I2C address
- MEAS_CMD, 8'hFD, measure command (high repeatability)
- WAIT_CYCLES, 900000, clk cycles between write completion and read request (≥ 8.3 ms at the system clock)
- MAX_RETRIES, 3, read re-attempts after a read NACK; range 0-7

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle trigger; ignored while busy=1
- txn_valid  out  1  transaction request to the I2C master
- txn_ready  in  1  master accepts the request when txn_valid & txn_ready
- txn_rw  out  1  0=write, 1=read
- txn_addr  out  7  always SHT_ADDR
- txn_len  out  3  byte count: 1 for write, 6 for read
- txn_wdata  out  8  MEAS_CMD
- rx_valid  in  1  one-cycle strobe, received byte on rx_data
- rx_data  in  8  received byte
- txn_done  in  1  one-cycle pulse at the end of the transaction (after STOP)
- txn_nack  in  1  valid with txn_done; 1 means the address or data was NACKed
- busy  out  1  high from the accepted start until return to IDLE
- data_valid  out  1  one-cycle pulse; temperature/humidity were updated this cycle
- temperature  out  16  raw ST word, MSB first as received
- humidity  out  16  raw SRH word
- err  out  1  one-cycle pulse; measurement aborted
- err_code  out  2  valid with err: 1=write NACK, 2=read NACK retries exhausted, 3=CRC mismatch

## Operation
- States: IDLE, WR_REQ, WR_WAIT, DELAY, RD_REQ, RD_WAIT, CHECK.
- IDLE: start=1 → WR_REQ, busy=1, retry counter cleared.
- WR_REQ: txn_valid=1, rw=0, len=1. Handshake → WR_WAIT.
- WR_WAIT: txn_done with nack=1 → err, code 1, go to IDLE. With nack=0 → DELAY, load counter.
- DELAY: counts WAIT_CYCLES cycles, then → RD_REQ.
- RD_REQ: txn_valid=1, rw=1, len=6. Handshake → RD_WAIT, byte index=0, CRC=8'hFF.
- RD_WAIT: each rx_valid stores the byte at the current index, then index+1. Index 0-1 = T word, 2 = T CRC, 3-4 = RH word, 5 = RH CRC.
  - CRC: poly 0x31, init 0xFF, MSB first, no final XOR. Each data byte is folded in within one cycle (all 8 shifts unrolled).
  - At index 2 the computed CRC is compared with the received byte, a mismatch flag is latched, and CRC resets to 0xFF. Index 5 does the same for the RH word.
  - Bytes beyond index 5 are ignored.
- RD_WAIT on txn_done:
  - If nack=1 or fewer than 6 bytes were received: if retries < MAX_RETRIES, increment retries and go to DELAY. Otherwise err, code 2, go to IDLE.
  - Otherwise → CHECK.
- CHECK: one cycle.
  - No mismatch: temperature and humidity are loaded from the staging registers, data_valid=1, go to IDLE.
  - Mismatch: err, code 3, outputs are not updated, go to IDLE.
- temperature and humidity change only on a data_valid cycle. Partially received bytes never reach the outputs.
- rx_valid and txn_done outside WR_WAIT/RD_WAIT are ignored.

## Timing
- Reset values: every output is 0 (txn_valid, busy, data_valid, err, err_code, temperature, humidity; txn_addr=SHT_ADDR and txn_wdata=MEAS_CMD are constants). State=IDLE, counters=0.
- rst mid-operation aborts at once. No err is pulsed and the outputs return to their reset values. Any transaction in flight in the master is the master's responsibility.
- txn_valid rises the cycle after entry to WR_REQ/RD_REQ and holds until the handshake. txn_rw and txn_len are stable while txn_valid=1. txn_valid drops the cycle after the handshake.
- DELAY lasts exactly WAIT_CYCLES cycles from the cycle after txn_done to the rising edge of txn_valid in RD_REQ.
- data_valid or err is asserted exactly one cycle after the final txn_done (CHECK cycle); busy falls the cycle after that.
- start during busy is dropped (no queueing). start in the same cycle as data_valid/err is dropped. start is accepted on the first IDLE cycle.
- rx_valid coinciding with txn_done: the byte is stored before the done is evaluated.

## Test plan
- Nominal: rx bytes BE EF 92 00 00 81, no NACK. Expect temperature=16'hBEEF, humidity=16'h0000, data_valid pulse, and no err.
- CRC fail: bytes BE EF 93 00 00 81. Expect err with err_code=3, outputs keep their previous values, and no data_valid.
- Write NACK: txn_done+txn_nack after the write. Expect err with err_code=1, no read request, and busy low after 2 cycles.
- Read retry: the first two reads NACK, the third returns the nominal bytes (MAX_RETRIES=3). Expect three DELAY periods of WAIT_CYCLES each, then data_valid with the nominal values. With four NACKs expect err_code=2.
- Short read: only 4 rx_valid before txn_done. This is treated as a NACK and the retry path is followed.
- Reset/start: assert rst during DELAY. Expect all outputs 0 the next cycle, no err, and a subsequent start completes normally. A start pulse while busy causes no second write request.
